// File: rtl/booth_mul_arbiter_if.sv
// Client and multiplier signal bundle for booth_mul_arbiter.
// master = clients plus multiplier side, slave = the arbiter.
interface booth_mul_arbiter_if #(
    parameter int W    = 8,
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] x_in;
    logic [NREQ*W-1:0] y_in;
    logic [NREQ-1:0]   ack;
    logic [2*W-1:0]    result;
    logic [IW-1:0]     result_id;
    logic              err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic              mul_done;
    logic [W-1:0]      mul_half;

    modport master (
        output req, x_in, y_in, mul_done, mul_half,
        input  ack, result, result_id, err, busy,
        input  mul_start, mul_x, mul_y
    );

    modport slave (
        input  req, x_in, y_in, mul_done, mul_half,
        output ack, result, result_id, err, busy,
        output mul_start, mul_x, mul_y
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among
// NREQ clients; collects the two result halves and acks the winner.
module booth_mul_arbiter #(
    parameter int W       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                rst,
    booth_mul_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RESP
    } state_e;

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     id_q;
    logic [NREQ-1:0]   ack_q;
    logic [2*W-1:0]    res_q;
    logic              err_q;
    logic              busy_q;
    logic              start_q;
    logic [W-1:0]      x_q;
    logic [W-1:0]      y_q;
    logic [TW-1:0]     timer_q;

    logic [IW-1:0]     gnt_d;
    logic              gnt_vld_d;
    logic [IW:0]       sum_d;
    logic [IW-1:0]     ptr_d;
    logic              tmo_d;

    // Scan downward so the closest requester at or after ptr wins last.
    always_comb begin
        gnt_d     = '0;
        gnt_vld_d = 1'b0;
        sum_d     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_d = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum_d >= (IW+1)'(NREQ)) begin
                sum_d = sum_d - (IW+1)'(NREQ);
            end
            if (bus.req[sum_d[IW-1:0]]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = sum_d[IW-1:0];
            end
        end
    end

    assign ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    assign tmo_d = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            ack_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            timer_q <= '0;
        end else begin
            ack_q   <= '0;
            start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        x_q     <= bus.x_in[int'(gnt_d)*W +: W];
                        y_q     <= bus.y_in[int'(gnt_d)*W +: W];
                        id_q    <= gnt_d;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (bus.mul_done) begin
                        res_q[2*W-1:W] <= bus.mul_half;
                        timer_q        <= '0;
                        state_q        <= S_WAIT_LO;
                    end else if (tmo_d) begin
                        err_q       <= 1'b1;
                        ack_q[id_q] <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (bus.mul_done) begin
                        res_q[W-1:0] <= bus.mul_half;
                        ack_q[id_q]  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (tmo_d) begin
                        err_q       <= 1'b1;
                        ack_q[id_q] <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESP: begin
                    err_q   <= 1'b0;
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = ack_q;
    assign bus.result    = res_q;
    assign bus.result_id = id_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = start_q;
    assign bus.mul_x     = x_q;
    assign bus.mul_y     = y_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomised bench for booth_mul_arbiter with a behavioural
// round-robin / signed-product reference and a multiplier model.
module tb_booth_mul_arbiter;
    localparam int W       = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst;

    booth_mul_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

    booth_mul_arbiter #(
        .W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] xs [NREQ];
    logic [W-1:0] ys [NREQ];
    int m_ptr     = 0;
    int mul_mode  = 0;  // 0 normal, 1 silent, 2 upper half only
    int force_dly = -1;
    int m_dly     = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.x_in[i*W +: W] = xs[i];
            bus.y_in[i*W +: W] = ys[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
        end
        pack_ops();
    endtask

    // Multiplier stand-in: after a random delay returns upper then lower half.
    initial begin
        int phase;
        int cnt;
        logic [2*W-1:0] prod;
        phase = 0;
        cnt   = 0;
        prod  = '0;
        bus.mul_done = 1'b0;
        bus.mul_half = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            bus.mul_half = W'($urandom);
            if (rst) begin
                phase = 0;
            end else if (phase == 1) begin
                if (cnt == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_half = prod[2*W-1:W];
                    phase = (mul_mode == 2) ? 0 : 2;
                end else begin
                    cnt--;
                end
            end else if (phase == 2) begin
                bus.mul_done = 1'b1;
                bus.mul_half = prod[W-1:0];
                phase = 0;
            end else if (bus.mul_start && mul_mode != 1) begin
                prod  = smul(bus.mul_x, bus.mul_y);
                m_dly = (force_dly >= 0) ? force_dly : $urandom_range(0, 3);
                cnt   = m_dly;
                phase = 1;
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, ".ack"}, bus.ack, 0);
        check({tag, ".res"}, bus.result, 0);
        check({tag, ".id"}, bus.result_id, 0);
        check({tag, ".err"}, bus.err, 0);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".start"}, bus.mul_start, 0);
        check({tag, ".mx"}, bus.mul_x, 0);
        check({tag, ".my"}, bus.mul_y, 0);
    endtask

    task automatic run_txn(input string tag, input int id,
                           input logic [2*W-1:0] exp_res, input bit exp_err,
                           input bit chk_res, input bit chk_lat);
        int cyc;
        int s_cyc;
        int starts;
        bit got;
        cyc = 0;
        s_cyc = -1;
        starts = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.mul_start) begin
                starts++;
                s_cyc = cyc;
                check({tag, ".mx"}, bus.mul_x, xs[id]);
                check({tag, ".my"}, bus.mul_y, ys[id]);
            end
            if (bus.ack != '0) got = 1'b1;
        end
        check({tag, ".gotack"}, got, 1);
        check({tag, ".ack"}, bus.ack, 64'(1) << id);
        check({tag, ".id"}, bus.result_id, id);
        check({tag, ".err"}, bus.err, exp_err);
        if (chk_res) check({tag, ".res"}, bus.result, exp_res);
        check({tag, ".starts"}, starts, 1);
        check({tag, ".startlat"}, s_cyc, 1);
        if (chk_lat) begin
            check({tag, ".acklat"}, cyc - s_cyc,
                  exp_err ? TIMEOUT + 1 : m_dly + 3);
        end
        @(negedge clk);
        check({tag, ".ackoff"}, bus.ack, 0);
        check({tag, ".idle"}, bus.busy, 0);
        m_ptr = (id + 1) % NREQ;
    endtask

    initial begin
        int id;
        bit seen;
        logic [NREQ-1:0] r;
        rst = 1'b1;
        bus.req = '0;
        bus.x_in = '0;
        bus.y_in = '0;
        repeat (3) @(negedge clk);
        check_quiet("rst");

        // all clients requesting from reset: 0,1,2,3,0
        rst = 1'b0;
        m_ptr = 0;
        rand_ops();
        bus.req = '1;
        for (int i = 0; i < 5; i++) begin
            id = rr_pick(m_ptr, bus.req);
            check("rr.order", id, i % NREQ);
            run_txn("rr", id, smul(xs[id], ys[id]), 1'b0, 1'b1, 1'b1);
        end
        bus.req = '0;

        xs[1] = 8'd7;
        ys[1] = 8'd6;
        pack_ops();
        bus.req = 4'b0010;
        run_txn("d7x6", 1, 16'h002A, 1'b0, 1'b1, 1'b1);

        xs[0] = 8'hFD;
        ys[0] = 8'd5;
        pack_ops();
        bus.req = 4'b0001;
        run_txn("neg", 0, 16'hFFF1, 1'b0, 1'b1, 1'b1);

        // move ptr to 2, then 0011 must wrap to 0 then go to 1
        rand_ops();
        bus.req = 4'b0010;
        run_txn("p2", 1, smul(xs[1], ys[1]), 1'b0, 1'b1, 1'b0);
        bus.req = 4'b0011;
        run_txn("wrap0", 0, smul(xs[0], ys[0]), 1'b0, 1'b1, 1'b0);
        run_txn("wrap1", 1, smul(xs[1], ys[1]), 1'b0, 1'b1, 1'b0);

        mul_mode = 1;
        bus.req = 4'b0100;
        run_txn("tmo_hi", 2, '0, 1'b1, 1'b0, 1'b1);
        mul_mode = 0;
        bus.req = 4'b1000;
        run_txn("after_tmo", 3, smul(xs[3], ys[3]), 1'b0, 1'b1, 1'b1);

        mul_mode = 2;
        bus.req = 4'b0001;
        run_txn("tmo_lo", 0, '0, 1'b1, 1'b0, 1'b0);

        // reset while the arbiter sits in WAIT_LO
        force_dly = 0;
        bus.req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mul_start;
        end
        check("mid.start", seen, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check_quiet("mid");
        rst = 1'b0;
        mul_mode = 0;
        force_dly = -1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ack != '0) seen = 1'b1;
        end
        check("mid.noack", seen, 0);
        m_ptr = 0;
        bus.req = 4'b1010;
        run_txn("post_rst", 1, smul(xs[1], ys[1]), 1'b0, 1'b1, 1'b1);

        for (int t = 0; t < 30; t++) begin
            rand_ops();
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            bus.req = r;
            id = rr_pick(m_ptr, r);
            run_txn("rand", id, smul(xs[id], ys[id]), 1'b0, 1'b1, 1'b1);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
